// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled 3-point majority bit decisions,
// optional odd/even parity, stop-bit check and one-cycle result strobes.
module uart_rx #(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy,
   output logic [2:0]           dbg_state_o
);
   localparam int unsigned DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned S_W     = $clog2(OVERSAMPLE);
   localparam int unsigned B_W     = $clog2(DATA_BITS);

   localparam logic [S_W-1:0] S_LO   = S_W'(OVERSAMPLE / 2 - 1);
   localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2);
   localparam logic [S_W-1:0] S_HI   = S_W'(OVERSAMPLE / 2 + 1);
   localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_t;

   state_t               state_q;
   logic                 rx_m_q, rx_s_q, rx_prev_q;
   logic [DIV_W-1:0]     div_q;
   logic [S_W-1:0]       s_q;
   logic [B_W-1:0]       bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [1:0]           samp_q;
   logic                 par_bad_q;
   logic                 tick, decide, bit_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         rx_m_q <= rx;
         rx_s_q <= rx_m_q;
      end
   end

   assign tick        = (div_q == DIV_W'(DIV - 1));
   assign decide      = tick && (s_q == S_HI);
   // Majority of the two stored samples and the live sample at S_HI.
   assign bit_d       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
   assign dbg_state_o = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rx_prev_q  <= 1'b1;
         div_q      <= '0;
         s_q        <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         samp_q     <= '0;
         par_bad_q  <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_prev_q  <= rx_s_q;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;

         if (tick) begin
            div_q <= '0;
            s_q   <= (s_q == S_LAST) ? '0 : s_q + S_W'(1);
            if (s_q == S_LO)  samp_q[0] <= rx_s_q;
            if (s_q == S_MID) samp_q[1] <= rx_s_q;
         end else begin
            div_q <= div_q + DIV_W'(1);
         end

         case (state_q)
            ST_IDLE: begin
               // Restart the divider and sample counter so samples align to this edge.
               if (rx_prev_q && !rx_s_q) begin
                  state_q   <= ST_START;
                  busy      <= 1'b1;
                  div_q     <= '0;
                  s_q       <= '0;
                  bit_q     <= '0;
                  par_bad_q <= 1'b0;
               end
            end
            ST_START: begin
               if (decide) begin
                  if (!bit_d) begin
                     state_q <= ST_DATA;
                  end else begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end
            end
            ST_DATA: begin
               if (decide) begin
                  shift_q <= {bit_d, shift_q[DATA_BITS-1:1]};
                  bit_q   <= bit_q + B_W'(1);
                  if (bit_q == B_W'(DATA_BITS - 1))
                     state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (decide) begin
                  par_bad_q <= (PARITY == 1) ? ~((^shift_q) ^ bit_d) : ((^shift_q) ^ bit_d);
                  state_q   <= ST_STOP;
               end
            end
            ST_STOP: begin
               // Leaving at mid-stop-bit lets an immediately following start bit be seen.
               if (decide) begin
                  if (bit_d) begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                     if (par_bad_q) begin
                        parity_err <= 1'b1;
                     end else begin
                        rx_valid <= 1'b1;
                        rx_data  <= shift_q;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state_q   <= ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s_q) begin
                  state_q <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver and an 8E1 receiver driven with directed and
// random frames; a per-receiver monitor matches each strobe against expected events.
module tb_uart_rx;
   localparam int BT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx0 = 1'b1;
   logic       rx1 = 1'b1;
   logic [7:0] rx_data0, rx_data1;
   logic       rx_valid0, frame_err0, parity_err0, busy0;
   logic       rx_valid1, frame_err1, parity_err1, busy1;
   logic [2:0] dbg0, dbg1;

   int unsigned cyc = 0;
   int errors = 0;
   int checks = 0;

   // Expected event: {strobe cycle[31:0], kind[1:0] (1 valid, 2 frame, 3 parity), rx_data[7:0]}
   logic [41:0] exp_q0[$];
   logic [41:0] exp_q1[$];
   logic [7:0]  good [2];

   uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)) dut0 (
      .clk(clk), .rst(rst), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
      .frame_err(frame_err0), .parity_err(parity_err0), .busy(busy0), .dbg_state_o(dbg0));

   uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2)) dut1 (
      .clk(clk), .rst(rst), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
      .frame_err(frame_err1), .parity_err(parity_err1), .busy(busy1), .dbg_state_o(dbg1));

   // Clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   task automatic mon(input int which, input logic v, input logic fe, input logic pe,
                      input logic [7:0] d, input logic b);
      logic [41:0] e;
      logic [1:0]  k;
      int          n;
      bit          empty;
      k = v ? 2'd1 : (fe ? 2'd2 : 2'd3);
      n = int'(v) + int'(fe) + int'(pe);
      check($sformatf("u%0d_exclusive", which), 64'(n), 64'd1);
      empty = (which == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
         checks++;
         errors++;
         $display("FAIL u%0d_unexpected: got strobe kind %0d data %0h at cycle %0d, expected none",
                  which, k, d, cyc);
      end else begin
         if (which == 0) e = exp_q0.pop_front();
         else            e = exp_q1.pop_front();
         check($sformatf("u%0d_cycle", which), 64'(cyc), 64'(e[41:10]));
         check($sformatf("u%0d_kind", which), 64'(k), 64'(e[9:8]));
         check($sformatf("u%0d_data", which), 64'(d), 64'(e[7:0]));
         check($sformatf("u%0d_busy_at_strobe", which), 64'(b), 64'(e[9:8] == 2'd2));
      end
   endtask

   always @(negedge clk)
      if (rst && (rx_valid0 || frame_err0 || parity_err0))
         mon(0, rx_valid0, frame_err0, parity_err0, rx_data0, busy0);

   always @(negedge clk)
      if (rst && (rx_valid1 || frame_err1 || parity_err1))
         mon(1, rx_valid1, frame_err1, parity_err1, rx_data1, busy1);

   // Drivers
   task automatic drive(input int which, input logic v, input int n);
      if (which == 0) rx0 = v;
      else            rx1 = v;
      repeat (n) @(negedge clk);
   endtask

   // Receiver 1 uses even parity. Strobe lands 3 sync/detect cycles + whole bits before
   // the stop bit + 9 samples into it + 1 register cycle after the pin falls.
   task automatic send_frame(input int which, input logic [7:0] d, input bit par_flip,
                             input bit stop_bad, input int hold_low);
      int          nb;
      logic        p;
      logic [1:0]  k;
      logic [7:0]  ed;
      logic [31:0] t;
      nb = (which == 1) ? 10 : 9;
      p  = (^d) ^ par_flip;
      t  = cyc + 32'(3 + nb * BT + 9 + 1);
      if (stop_bad) begin
         k = 2'd2; ed = good[which];
      end else if (which == 1 && par_flip) begin
         k = 2'd3; ed = good[which];
      end else begin
         k = 2'd1; ed = d; good[which] = d;
      end
      if (which == 0) exp_q0.push_back({t, k, ed});
      else            exp_q1.push_back({t, k, ed});
      drive(which, 1'b0, BT);
      check($sformatf("u%0d_busy_mid", which), 64'((which == 0) ? busy0 : busy1), 64'd1);
      for (int i = 0; i < 8; i++) drive(which, d[i], BT);
      if (which == 1) drive(which, p, BT);
      drive(which, !stop_bad, BT);
      if (stop_bad) begin
         check($sformatf("u%0d_busy_break", which), 64'((which == 0) ? busy0 : busy1), 64'd1);
         drive(which, 1'b0, hold_low);
         drive(which, 1'b1, BT);
      end
   endtask

   // Stimulus
   initial begin
      int unsigned t0;
      good[0] = '0;
      good[1] = '0;
      repeat (4) @(negedge clk);
      check("rst_data0", 64'(rx_data0), 64'd0);
      check("rst_valid0", 64'(rx_valid0), 64'd0);
      check("rst_ferr0", 64'(frame_err0), 64'd0);
      check("rst_perr0", 64'(parity_err0), 64'd0);
      check("rst_busy0", 64'(busy0), 64'd0);
      check("rst_data1", 64'(rx_data1), 64'd0);
      check("rst_busy1", 64'(busy1), 64'd0);
      rst = 1'b1;
      repeat (2 * BT) @(negedge clk);

      send_frame(0, 8'hA5, 1'b0, 1'b0, 0);
      repeat (BT) @(negedge clk);
      send_frame(0, 8'h00, 1'b0, 1'b0, 0);
      send_frame(0, 8'hFF, 1'b0, 1'b0, 0);
      repeat (2 * BT) @(negedge clk);

      t0  = cyc;
      rx0 = 1'b0;
      repeat (6) @(negedge clk);
      rx0 = 1'b1;
      repeat (2) @(negedge clk);
      check("glitch_busy_high", 64'(busy0), 64'd1);
      repeat (8) @(negedge clk);
      check("glitch_busy_low", 64'(busy0), 64'd0);
      check("glitch_cycles", 64'(cyc - t0), 64'd16);
      check("glitch_data", 64'(rx_data0), 64'(good[0]));
      repeat (2 * BT) @(negedge clk);

      send_frame(0, 8'h3C, 1'b0, 1'b1, 40 * BT);
      check("break_data_held", 64'(rx_data0), 64'hFF);
      repeat (2 * BT) @(negedge clk);
      send_frame(0, 8'h11, 1'b0, 1'b0, 0);
      repeat (2 * BT) @(negedge clk);

      send_frame(1, 8'h07, 1'b0, 1'b0, 0);
      repeat (BT) @(negedge clk);
      send_frame(1, 8'h07, 1'b1, 1'b0, 0);
      check("parity_data_held", 64'(rx_data1), 64'h07);
      repeat (2 * BT) @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         int   w;
         logic [7:0] d;
         bit   sb, pf;
         w  = i % 2;
         d  = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 7) == 0);
         pf = (w == 1) && ($urandom_range(0, 3) == 0);
         send_frame(w, d, pf, sb, int'($urandom_range(0, 32)));
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      repeat (2 * BT) @(negedge clk);

      drive(0, 1'b0, BT);
      for (int i = 0; i < 4; i++) drive(0, 1'(8'h5A >> i), BT);
      drive(0, 1'b1, BT / 2);
      #2 rst = 1'b0;
      #1;
      check("midrst_data0", 64'(rx_data0), 64'd0);
      check("midrst_valid0", 64'(rx_valid0), 64'd0);
      check("midrst_ferr0", 64'(frame_err0), 64'd0);
      check("midrst_perr0", 64'(parity_err0), 64'd0);
      check("midrst_busy0", 64'(busy0), 64'd0);
      check("midrst_data1", 64'(rx_data1), 64'd0);
      good[0] = '0;
      good[1] = '0;
      rx0 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2 * BT) @(negedge clk);
      send_frame(0, 8'h5A, 1'b0, 1'b0, 0);
      repeat (4 * BT) @(negedge clk);

      check("u0_pending", 64'(exp_q0.size()), 64'd0);
      check("u1_pending", 64'(exp_q1.size()), 64'd0);
      $display("final receiver states %0d %0d", dbg0, dbg1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side UART deserializer on the board RX pin; mirror of the transmit path in the transceiver.
- Synchronizes the asynchronous rx line and oversamples it. Validates the start bit, shifts in DATA_BITS LSB-first, optionally checks parity, and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe. The byte drives the board LEDs and any downstream consumer.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; even, >= 8.
- DATA_BITS, 8, data bits per frame; 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rx  in  1  serial input from board RX pin, asynchronous, idle high.
- rx_data  out  DATA_BITS  last good received word; holds until the next good frame.
- rx_valid  out  1  one-cycle pulse: rx_data updated this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch; always 0 when PARITY=0.
- busy  out  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset (rst low, async): all state goes to IDLE, outputs go to 0, tick/bit counters clear, and synchronizer flops preset to 1.
- Synchronizer: 2-flop on rx. All logic uses the synchronized value rx_s.
- Tick generator: divisor DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)), minimum 1. tick pulses once per DIV cycles. The divider restarts on entry to START so samples align to the detected edge.
- Sample counter s runs 0..OVERSAMPLE-1 per bit, advancing on tick.
- Bit decision: majority of rx_s at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is evaluated on the tick where s = OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rx_s 1->0 transition -> START, busy=1.
  - START: at decision, 0 -> DATA; 1 (glitch) -> IDLE with no pulse.
  - DATA: decide each bit into the shift register LSB-first. After DATA_BITS decisions -> PARITY if PARITY!=0, else STOP.
  - PARITY: compute the expected parity over the data bits (odd: ones+p odd; even: ones+p even). Record mismatch, then -> STOP.
  - STOP, decision = 1: rx_data <= shift register. Pulse rx_valid, or pulse parity_err instead if a mismatch was recorded (rx_data is then not updated). Then -> IDLE.
  - STOP, decision = 0: pulse frame_err, leave rx_data unchanged, -> BREAK.
  - BREAK: wait for rx_s = 1, then -> IDLE. A line held low never produces a second frame.
- Early return: IDLE is re-entered at mid-stop-bit, so a start bit arriving immediately after the stop bit is detected.
- Exclusivity: rx_valid, frame_err and parity_err are mutually exclusive, and each is high exactly one cycle per frame.
- Output timing: strobe asserts on the clock edge after the stop decision tick. busy deasserts in that same cycle.
- Latency (DIV=1, OS=16): pin falling edge to rx_valid = 2 sync + 1 edge detect + (1+DATA_BITS+P)*16 + 9 + 1 cycles, where P=1 when parity is enabled. For 8N1 this is 157 cycles.
- Falling edges seen outside IDLE are ignored.
- rst asserted mid-frame: immediate IDLE, no strobe. After release, the first frame starting with a clean falling edge is received normally.

Test Plan (CLK_FREQ=1_600_000, BAUD=100_000, OS=16, so DIV=1 and a bit is 16 cycles, unless noted):
- 8N1 byte 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) -> one rx_valid pulse 157 cycles after the pin falling edge, rx_data=0xA5, frame_err=0, busy high throughout the frame.
- Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses 160 cycles apart, rx_data 0x00 then 0xFF.
- 6-cycle low glitch on idle rx -> no strobe; busy high for about 10 cycles then low; rx_data unchanged.
- 0x3C with stop bit forced 0, then rx held low 40 bit-times, then 0x11 -> frame_err pulses once, no rx_valid, and rx_data remains the prior value until 0x11 is received. Only the single 0x11 rx_valid follows.
- PARITY=2, 0x07 with correct parity bit 1 -> rx_valid, rx_data=0x07. Same frame with parity bit 0 -> parity_err pulse, rx_valid=0, rx_data unchanged.
- rst pulsed low in the middle of data bit 4 of 0x5A -> all outputs 0 immediately and no strobe. A following 0x5A frame -> rx_valid, rx_data=0x5A.
